// File: rtl/mw_countdown_timer.sv
// BCD minutes:seconds countdown timer for the microwave controller.
// Optional beep output is enabled by defining MW_TIMER_BEEP_EN.
//
// state  | meaning
// IDLE   | count 0:00, not just expired
// SET    | count nonzero, magnetron off
// RUN    | count nonzero, magnetron on, counting down
// DONE   | count reached 0:00 by a tick
module mw_countdown_timer #(
  parameter int TICKS_PER_SEC = 1000,
  parameter int BEEP_SECS     = 3
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       clearn,
  input  logic       mag_on,
  input  logic       digit_valid,
  input  logic [3:0] digit_in,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       timer_done
`ifdef MW_TIMER_BEEP_EN
  , output logic     beep
`endif
);

  localparam int PW = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SET  = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  if (TICKS_PER_SEC < 2 || BEEP_SECS < 1) begin : g_param_check
    $error("mw_countdown_timer: TICKS_PER_SEC must be >= 2 and BEEP_SECS >= 1");
  end

  logic [PW-1:0] presc;
  logic [1:0]    state, state_nxt;
  logic [3:0]    mt_dec, mo_dec, st_dec, so_dec;
  logic          b_so, b_st, b_mo;
  logic          count_zero, entry, entry_zero, run_en, tick, dec_zero;

  assign count_zero = (min_tens == 4'd0) && (min_ones == 4'd0) &&
                      (sec_tens == 4'd0) && (sec_ones == 4'd0);
  assign timer_done = count_zero;

  assign entry      = digit_valid && !mag_on && (digit_in <= 4'd9);
  assign entry_zero = (min_ones == 4'd0) && (sec_tens == 4'd0) &&
                      (sec_ones == 4'd0) && (digit_in == 4'd0);

  // A zero count blocks the prescaler, so the borrow chain never underflows.
  assign run_en = mag_on && !count_zero;
  assign tick   = run_en && (presc == PRESC_MAX);

  always_comb begin
    b_so   = (sec_ones == 4'd0);
    so_dec = b_so ? 4'd9 : sec_ones - 4'd1;
    b_st   = 1'b0;
    st_dec = sec_tens;
    if (b_so) begin
      b_st   = (sec_tens == 4'd0);
      st_dec = b_st ? 4'd5 : sec_tens - 4'd1;
    end
    b_mo   = 1'b0;
    mo_dec = min_ones;
    if (b_st) begin
      b_mo   = (min_ones == 4'd0);
      mo_dec = b_mo ? 4'd9 : min_ones - 4'd1;
    end
    mt_dec = b_mo ? min_tens - 4'd1 : min_tens;
  end

  assign dec_zero = (mt_dec == 4'd0) && (mo_dec == 4'd0) &&
                    (st_dec == 4'd0) && (so_dec == 4'd0);

  always_comb begin
    state_nxt = state;
    if (!clearn) begin
      state_nxt = S_IDLE;
    end else if (entry) begin
      state_nxt = entry_zero ? S_IDLE : S_SET;
    end else if (tick && dec_zero) begin
      state_nxt = S_DONE;
    end else begin
      case (state)
        S_SET:   if (mag_on) state_nxt = S_RUN;
        S_RUN:   if (!mag_on) state_nxt = S_SET;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= S_IDLE;
      presc    <= '0;
      min_tens <= 4'd0;
      min_ones <= 4'd0;
      sec_tens <= 4'd0;
      sec_ones <= 4'd0;
    end else begin
      state <= state_nxt;
      if (!clearn) begin
        presc    <= '0;
        min_tens <= 4'd0;
        min_ones <= 4'd0;
        sec_tens <= 4'd0;
        sec_ones <= 4'd0;
      end else if (entry) begin
        presc    <= '0;
        min_tens <= min_ones;
        min_ones <= sec_tens;
        sec_tens <= sec_ones;
        sec_ones <= digit_in;
      end else if (tick) begin
        presc    <= '0;
        min_tens <= mt_dec;
        min_ones <= mo_dec;
        sec_tens <= st_dec;
        sec_ones <= so_dec;
      end else if (run_en) begin
        presc <= presc + 1'b1;
      end
    end
  end

`ifdef MW_TIMER_BEEP_EN
  localparam int BEEP_CYC = BEEP_SECS * TICKS_PER_SEC;
  localparam int BW       = $clog2(BEEP_CYC + 1);

  logic [BW-1:0] beep_cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      beep_cnt <= '0;
    end else if (!clearn || entry) begin
      beep_cnt <= '0;
    end else if (tick && dec_zero) begin
      beep_cnt <= BW'(BEEP_CYC);
    end else if (beep_cnt != '0) begin
      beep_cnt <= beep_cnt - 1'b1;
    end
  end

  assign beep = (beep_cnt != '0);
`endif

endmodule

// File: doc/mw_countdown_timer.md
Name: mw_countdown_timer

Overview:
- BCD minutes:seconds countdown timer for the microwave controller. It is the producer of `timer_done` and the consumer of `mag_on` for the control block.
- Keypad digits are shifted in while the magnetron is off. The count decrements once per second while `mag_on` is high.
- `timer_done` is asserted whenever the count is 0:00, so the control block drops `mag_on`.

Parameters:
- TICKS_PER_SEC, default 1000: `clk` cycles per one-second decrement; must be >= 2.
- BEEP_SECS, default 3: beep duration in seconds; used only with MW_TIMER_BEEP_EN.

Ports:
- clk  input  1  system clock; all logic on rising edge
- resetn  input  1  asynchronous, active-low reset
- clearn  input  1  synchronous active-low clear of count and prescaler
- mag_on  input  1  count enable from control block
- digit_valid  input  1  one-cycle strobe: digit_in is a new keypad digit
- digit_in  input  4  keypad digit, BCD 0-9
- min_tens  output  4  BCD minutes tens
- min_ones  output  4  BCD minutes ones
- sec_tens  output  4  BCD seconds tens
- sec_ones  output  4  BCD seconds ones
- timer_done  output  1  high iff all four digits are 0
- beep  output  1  only with MW_TIMER_BEEP_EN

Behaviour:
- Reset (resetn=0, asynchronous):
  - all digits 0, prescaler 0, FSM=IDLE, beep 0.
  - timer_done=1, because the count is 0:00.
- timer_done is decoded directly from the digit registers. It adds no latency beyond the register update.
- Priority per cycle: resetn > clearn > digit entry > countdown.
- clearn=0 at a rising edge:
  - digits and prescaler go to 0; FSM goes to IDLE; beep goes to 0.
  - This takes effect even while mag_on=1.
- Digit entry, when digit_valid=1, mag_on=0 and digit_in<=9:
  - shift left: min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=digit_in.
  - The old min_tens is discarded.
  - FSM goes to SET (or to IDLE if the result is 0:00).
  - The prescaler resets to 0.
- Digit entry is ignored when digit_in>9 or when mag_on=1.
- sec_tens values 6-9 are accepted on entry (for example 1:90). They are never normalised; they count down naturally.
- Prescaler:
  - increments only when mag_on=1 and the count is nonzero.
  - At TICKS_PER_SEC-1 it wraps to 0 and issues an internal tick.
  - While mag_on=0 it holds its value, so a paused partial second is preserved.
- Decrement on tick, as a BCD borrow chain:
  - sec_ones: 0 becomes 9 and borrows; otherwise it decrements.
  - sec_tens: 0 becomes 5 and borrows; otherwise it decrements.
  - min_ones: 0 becomes 9 and borrows; otherwise it decrements.
  - min_tens: decrements.
  - The count never decrements below 0:00. The count being zero blocks ticks.
- FSM states:
  - IDLE: count 0:00, not just expired.
  - SET: count nonzero, mag_on=0.
  - RUN: count nonzero, mag_on=1.
  - DONE: count reached 0:00 by a tick.
- FSM transitions:
  - SET -> RUN when mag_on=1.
  - RUN -> SET when mag_on=0 (pause).
  - RUN -> DONE on a tick that produces 0:00.
  - DONE -> SET or IDLE on digit entry.
  - any state -> IDLE on clearn=0.
  - IDLE with mag_on=1 stays IDLE; timer_done is already 1.
- In DONE, mag_on is ignored (no counting).

Optional Feature:
- MW_TIMER_BEEP_EN defined:
  - on entry to DONE, beep=1 for BEEP_SECS*TICKS_PER_SEC cycles, timed by a dedicated counter, then beep=0.
  - clearn=0 or digit entry terminates beep immediately.
  - The beep counter resets to 0.
- MW_TIMER_BEEP_EN undefined: beep port absent; no beep counter.

Test Plan (TICKS_PER_SEC=4, BEEP_SECS=2):
- Reset, then enter digits 1,3,0 with mag_on=0 -> digits read 0:1:3:0 (1:30), timer_done=0, prescaler idle.
- Load 0:05, mag_on=1 held -> count becomes 0:04 after 4 clks, 0:00 after 20 clks. timer_done rises on the same edge the count reaches 0:00. The count then stays 0:00 with mag_on still 1.
- Load 1:00, run 4 clks -> 0:59. Load 1:90, run 4 clks -> 1:89. Run from 1:00 through 0:00 -> no negative digits.
- Load 0:03, mag_on=1 for 2 clks, 0 for 10 clks, then 1 -> 0:02 appears 2 clks after resume (fraction preserved). Digit_valid pulses during mag_on=1 leave the count unchanged.
- During RUN at 0:42, drive clearn=0 for one clk -> 0:00, timer_done=1. Assert resetn=0 mid-cycle (between edges) -> outputs 0 immediately, without waiting for a clock edge.
- With MW_TIMER_BEEP_EN: countdown 0:01 to 0:00 -> beep high for exactly 8 clks. Repeat, and enter a digit at clk 3 of beep -> beep low on the next edge.
